// File: rtl/param_sync_fifo_pkg.sv
// Shared defaults and depth derivation for every FIFO variant in the codebase.
package param_sync_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_ADDR_WIDTH = 2;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage, one write port and one registered read port.
// Read data appears one edge after rd_en and is zero in any cycle without a read.
module fifo_mem
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Storage is intentionally not reset; occupancy tracking makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
    else            rd_data <= '0;
  end
endmodule

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO with runtime almost-full/empty thresholds and sticky error flags.
// Read latency one cycle; writes while full (without a read) and reads while empty are dropped and flagged.
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_enable,
  input  logic                  rd_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   almost_full_th,
  input  logic [ADDR_WIDTH:0]   almost_empty_th,
  input  logic                  err_clear,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full_fifo,
  output logic                  empty_fifo,
  output logic                  almost_full_fifo,
  output logic                  almost_empty_fifo,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow_err,
  output logic                  underflow_err
);
  localparam int                DEPTH     = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   af_level;
  logic                  wr_acc, rd_acc;

  // No read-through: a read into an empty FIFO fails even if a write lands in the same cycle.
  assign rd_acc = rd_enable && !empty_fifo;
  assign wr_acc = wr_enable && (!full_fifo || rd_acc);

  assign full_fifo         = (fifo_count == DEPTH_CNT);
  assign empty_fifo        = (fifo_count == '0);
  assign af_level          = (almost_full_th > DEPTH_CNT) ? DEPTH_CNT : almost_full_th;
  assign almost_full_fifo  = (fifo_count >= af_level);
  assign almost_empty_fifo = (fifo_count <= almost_empty_th);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      valid_out     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
      valid_out <= rd_acc;
      // A new error outranks a simultaneous clear.
      if (wr_enable && !wr_acc) overflow_err <= 1'b1;
      else if (err_clear)       overflow_err <= 1'b0;
      if (rd_enable && !rd_acc) underflow_err <= 1'b1;
      else if (err_clear)       underflow_err <= 1'b0;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );
endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_param_sync_fifo;
  localparam int DW = 6;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, wr_enable, rd_enable, err_clear;
  logic [DW-1:0] data_in;
  logic [AW:0]   almost_full_th, almost_empty_th;
  logic [DW-1:0] data_out;
  logic          valid_out, full_fifo, empty_fifo, almost_full_fifo, almost_empty_fifo;
  logic [AW:0]   fifo_count;
  logic          overflow_err, underflow_err;

  int checks = 0;
  int passes = 0;

  // Reference model: contents as a queue, plus expected registered outputs and sticky errors.
  logic [DW-1:0] q[$];
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          m_ovf = 1'b0, m_udf = 1'b0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .wr_enable(wr_enable), .rd_enable(rd_enable),
    .data_in(data_in), .almost_full_th(almost_full_th), .almost_empty_th(almost_empty_th),
    .err_clear(err_clear), .data_out(data_out), .valid_out(valid_out),
    .full_fifo(full_fifo), .empty_fifo(empty_fifo), .almost_full_fifo(almost_full_fifo),
    .almost_empty_fifo(almost_empty_fifo), .fifo_count(fifo_count),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  // Drive one cycle of inputs, advance the model across the edge, then settle past the edge.
  task automatic step(input logic rst, input logic wr, input logic rd,
                      input logic [DW-1:0] din, input logic clr);
    bit racc, wacc;
    reset = rst; wr_enable = wr; rd_enable = rd; data_in = din; err_clear = clr;
    @(posedge clk);
    if (rst) begin
      q.delete(); m_valid = 1'b0; m_data = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      racc = rd && (q.size() > 0);
      wacc = wr && ((q.size() < DEPTH) || racc);
      m_valid = racc;
      m_data  = '0;
      if (racc) m_data = q.pop_front();
      if (wacc) q.push_back(din);
      m_ovf = (wr && !wacc) || (m_ovf && !clr);
      m_udf = (rd && !racc) || (m_udf && !clr);
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 1, 6'h15, 0);
    step(1, 0, 0, 0, 0);
    checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else passes++;
    checks++; if ({empty_fifo, full_fifo, almost_empty_fifo} !== 3'b101)
      $display("FAIL reset_flags got e/f/ae=%b%b%b want 101", empty_fifo, full_fifo, almost_empty_fifo); else passes++;
    checks++; if ({valid_out, data_out, overflow_err, underflow_err} !== 9'd0)
      $display("FAIL reset_outputs got v=%b d=%h ovf=%b udf=%b want all 0", valid_out, data_out, overflow_err, underflow_err);
    else passes++;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) step(0, 1, 0, DW'(i), 0);
    checks++; if (fifo_count !== 3'd4 || full_fifo !== 1'b1)
      $display("FAIL fill_full got count=%0d full=%b want 4/1", fifo_count, full_fifo); else passes++;
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 1, 0, 0);
      checks++; if (valid_out !== 1'b1 || data_out !== DW'(i))
        $display("FAIL drain_data got v=%b d=%h want 1/%h", valid_out, data_out, DW'(i)); else passes++;
    end
    checks++; if (empty_fifo !== 1'b1 || fifo_count !== 3'd0)
      $display("FAIL drain_empty got empty=%b count=%0d want 1/0", empty_fifo, fifo_count); else passes++;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) step(0, 1, 0, DW'(i), 0);
    step(0, 1, 0, 6'h05, 0);
    checks++; if (overflow_err !== 1'b1 || fifo_count !== 3'd4)
      $display("FAIL overflow_set got ovf=%b count=%0d want 1/4", overflow_err, fifo_count); else passes++;
    step(0, 0, 1, 0, 0);
    checks++; if (data_out !== 6'h01 || valid_out !== 1'b1)
      $display("FAIL overflow_nocorrupt got d=%h v=%b want 01/1", data_out, valid_out); else passes++;
    step(0, 0, 0, 0, 1);
    checks++; if (overflow_err !== 1'b0) $display("FAIL overflow_clear got %b want 0", overflow_err); else passes++;
  endtask

  task automatic test_full_rw();
    step(0, 1, 0, 6'h05, 0);
    checks++; if (full_fifo !== 1'b1) $display("FAIL full_rw_pre got full=%b want 1", full_fifo); else passes++;
    step(0, 1, 1, 6'h06, 0);
    checks++; if (fifo_count !== 3'd4 || overflow_err !== 1'b0 || data_out !== 6'h02 || valid_out !== 1'b1)
      $display("FAIL full_rw got count=%0d ovf=%b d=%h v=%b want 4/0/02/1", fifo_count, overflow_err, data_out, valid_out);
    else passes++;
    for (int i = 3; i <= 6; i++) begin
      step(0, 0, 1, 0, 0);
      checks++; if (data_out !== DW'(i)) $display("FAIL full_rw_drain got %h want %h", data_out, DW'(i)); else passes++;
    end
  endtask

  task automatic test_underflow();
    step(0, 1, 1, 6'h2A, 0);
    checks++; if (underflow_err !== 1'b1 || valid_out !== 1'b0 || fifo_count !== 3'd1)
      $display("FAIL underflow got udf=%b v=%b count=%0d want 1/0/1", underflow_err, valid_out, fifo_count); else passes++;
    step(0, 0, 1, 0, 1);
    checks++; if (data_out !== 6'h2A || valid_out !== 1'b1 || underflow_err !== 1'b0)
      $display("FAIL underflow_read got d=%h v=%b udf=%b want 2a/1/0", data_out, valid_out, underflow_err); else passes++;
  endtask

  task automatic test_wrap();
    logic [2:0] exp_flags [3] = '{3'b010, 3'b000, 3'b100};
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, DW'(40 + i), 0);
      checks++; if ({almost_full_fifo, almost_empty_fifo, 1'b0} !== exp_flags[i] || fifo_count !== 3'(i + 1))
        $display("FAIL wrap_flags count=%0d got af/ae=%b%b want %b", fifo_count, almost_full_fifo,
                 almost_empty_fifo, exp_flags[i][2:1]); else passes++;
    end
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 1, DW'((k * 7 + 3) & 63), 0);
      checks++; if (data_out !== m_data || valid_out !== 1'b1 || fifo_count !== 3'd3)
        $display("FAIL wrap_pair %0d got d=%h v=%b count=%0d want %h/1/3", k, data_out, valid_out, fifo_count, m_data);
      else passes++;
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 0, 0);
      checks++; if (data_out !== m_data) $display("FAIL wrap_drain got %h want %h", data_out, m_data); else passes++;
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0, DW'(20 + i), 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 6'h33, 0);
    checks++; if (fifo_count !== 3'd3) $display("FAIL mid_reset_pre got %0d want 3", fifo_count); else passes++;
    step(1, 1, 1, 6'h11, 0);
    checks++; if (fifo_count !== 3'd0 || empty_fifo !== 1'b1 || valid_out !== 1'b0 || data_out !== '0)
      $display("FAIL mid_reset got count=%0d e=%b v=%b d=%h want 0/1/0/00", fifo_count, empty_fifo, valid_out, data_out);
    else passes++;
  endtask

  task automatic test_random();
    logic [16:0] obs, exp;
    logic [AW:0] af_lvl;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) begin
        almost_full_th  = 3'($urandom_range(0, 7));
        almost_empty_th = 3'($urandom_range(0, 7));
      end
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
           DW'($urandom), $urandom_range(0, 7) == 0);
      af_lvl = (almost_full_th > 3'(DEPTH)) ? 3'(DEPTH) : almost_full_th;
      obs = {valid_out, data_out, fifo_count, full_fifo, empty_fifo, almost_full_fifo,
             almost_empty_fifo, overflow_err, underflow_err, 1'b0};
      exp = {m_valid, m_data, 3'(q.size()), q.size() == DEPTH, q.size() == 0,
             3'(q.size()) >= af_lvl, 3'(q.size()) <= almost_empty_th, m_ovf, m_udf, 1'b0};
      checks++; if (obs !== exp)
        $display("FAIL random cycle %0d got v,d,cnt,f,e,af,ae,ovf,udf=%b want %b", c, obs, exp); else passes++;
    end
  endtask

  initial begin
    almost_full_th  = 3'd3;
    almost_empty_th = 3'd1;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
